irq_controller: RTL and testbench

Interrupt controller sitting in front of the coprocessor-0 block of the unpipelined MIPS core. It synchronises N asynchronous interrupt lines and latches rising edges as pending. It arbitrates pending, unmasked lines by fixed priority and presents exactly one request at a time on the coprocessor's single external-interrupt input. It tracks that request through acceptance and `eret`, and exposes mask/pending/ID registers to software.

---
 rtl/irq_ctrl_pkg.sv | 28 ++
 rtl/irq_controller_if.sv | 24 ++
 rtl/irq_sync_edge.sv | 24 ++
 rtl/irq_controller.sv | 103 ++++++++++
 tb/tb_irq_controller.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/irq_ctrl_pkg.sv
// Shared types for the interrupt controller: FSM states, register map, ID layout.
// Includes the fixed-priority helper used to pick the lowest pending, unmasked line.
package irq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQUEST = 2'd1,
        ST_SERVICE = 2'd2
    } irq_state_e;

    localparam logic [1:0] ADDR_MASK    = 2'd0;
    localparam logic [1:0] ADDR_PENDING = 2'd1;
    localparam logic [1:0] ADDR_ID      = 2'd2;
    localparam logic [1:0] ADDR_STATE   = 2'd3;

    localparam int ID_VALID_BIT = 31;

    // Lowest set bit wins; returns 0 when nothing is set (callers gate on any-set).
    function automatic int unsigned lowest_set(input logic [15:0] v);
        int unsigned idx;
        idx = 0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/irq_controller_if.sv
// Register bus plus coprocessor handshake between the MIPS core and the interrupt controller.
// The master side is the core; the slave side is irq_controller.
interface irq_controller_if #(
    parameter int ID_W = 4
);
    logic            i_we;
    logic [1:0]      i_addr;
    logic [31:0]     i_wdata;
    logic [31:0]     o_rdata;
    logic            i_exception;
    logic            i_eret;
    logic            o_external_interrupt;
    logic [ID_W-1:0] o_irq_id;

    modport master (
        output i_we, i_addr, i_wdata, i_exception, i_eret,
        input  o_rdata, o_external_interrupt, o_irq_id
    );

    modport slave (
        input  i_we, i_addr, i_wdata, i_exception, i_eret,
        output o_rdata, o_external_interrupt, o_irq_id
    );
endinterface

// File: rtl/irq_sync_edge.sv
// One interrupt line: 2-flop synchroniser then edge register; o_rise pulses for one cycle
// two edges after the raw line rises, so the consumer latches it on the third edge. No backpressure.
module irq_sync_edge (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_rise
);
    logic sync1, sync2, prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= i_async;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign o_rise = sync2 & ~prev;
endmodule

// File: rtl/irq_controller.sv
// Latches synchronised rising edges as pending and presents one fixed-priority request at a time;
// request is registered (1 cycle after pending), held until exception accepts it or it is withdrawn.
module irq_controller
    import irq_ctrl_pkg::*;
#(
    parameter int N_IRQ = 8,
    parameter int ID_W  = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [N_IRQ-1:0] i_irq,
    irq_controller_if.slave  bus
);
    logic [N_IRQ-1:0] rise, pending, pending_nxt, mask, cand, id_sel;
    logic [ID_W-1:0]  winner, id_q;
    logic             ext_q, wr_mask, wr_pend, accept, id_live;
    irq_state_e       state;

    for (genvar k = 0; k < N_IRQ; k++) begin : g_line
        irq_sync_edge u_sync (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_async (i_irq[k]),
            .o_rise  (rise[k])
        );
    end

    assign cand    = pending & mask;
    assign winner  = ID_W'(lowest_set(16'(cand)));
    assign id_sel  = N_IRQ'(1) << id_q;
    assign id_live = |(pending & mask & id_sel);
    assign wr_mask = bus.i_we && (bus.i_addr == ADDR_MASK);
    assign wr_pend = bus.i_we && (bus.i_addr == ADDR_PENDING);
    assign accept  = (state == ST_REQUEST) && bus.i_exception;

    // A fresh edge is OR-ed in last so it survives a same-cycle W1C or acceptance clear.
    always_comb begin
        pending_nxt = pending;
        if (wr_pend) pending_nxt = pending_nxt & ~bus.i_wdata[N_IRQ-1:0];
        if (accept)  pending_nxt = pending_nxt & ~id_sel;
        pending_nxt = pending_nxt | rise;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pending <= '0;
            mask    <= '0;
        end else begin
            pending <= pending_nxt;
            if (wr_mask) mask <= bus.i_wdata[N_IRQ-1:0];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
            ext_q <= 1'b0;
            id_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|cand) begin
                        id_q  <= winner;
                        ext_q <= 1'b1;
                        state <= ST_REQUEST;
                    end
                end
                ST_REQUEST: begin
                    if (bus.i_exception) begin
                        ext_q <= 1'b0;
                        state <= ST_SERVICE;
                    end else if (!id_live) begin
                        ext_q <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                ST_SERVICE: begin
                    if (bus.i_eret) state <= ST_IDLE;
                end
                default: begin
                    ext_q <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.o_external_interrupt = ext_q;
    assign bus.o_irq_id             = id_q;

    always_comb begin
        bus.o_rdata = '0;
        case (bus.i_addr)
            ADDR_MASK:    bus.o_rdata = 32'(mask);
            ADDR_PENDING: bus.o_rdata = 32'(pending);
            ADDR_ID: begin
                bus.o_rdata[ID_W-1:0]    = id_q;
                bus.o_rdata[ID_VALID_BIT] = (state == ST_REQUEST) || (state == ST_SERVICE);
            end
            default:      bus.o_rdata = 32'(state);
        endcase
    end
endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: edge latency, priority, withdraw, re-pend, W1C race, async reset.
module tb_irq_controller;
    import irq_ctrl_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [7:0] irq;
    int         total;
    int         bad;

    irq_controller_if #(.ID_W(4)) bus ();

    irq_controller #(.N_IRQ(8), .ID_W(4)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_irq   (irq),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
        bus.i_addr = a;
        #1;
        chk(tag, bus.o_rdata, exp);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.i_we    = 1'b1;
        bus.i_addr  = a;
        bus.i_wdata = d;
        step(1);
        bus.i_we    = 1'b0;
        bus.i_wdata = '0;
    endtask

    task automatic pulse_exc();
        bus.i_exception = 1'b1;
        step(1);
        bus.i_exception = 1'b0;
    endtask

    task automatic pulse_eret();
        bus.i_eret = 1'b1;
        step(1);
        bus.i_eret = 1'b0;
    endtask

    task automatic chk_req(input string tag, input logic ext, input logic [3:0] id);
        chk({tag, "_ext"}, 32'(bus.o_external_interrupt), 32'(ext));
        chk({tag, "_id"},  32'(bus.o_irq_id), 32'(id));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        irq   = '0;
        bus.i_we = 1'b0;
        bus.i_addr = '0;
        bus.i_wdata = '0;
        bus.i_exception = 1'b0;
        bus.i_eret = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);

        // Reset state
        chk_req("rst", 1'b0, 4'd0);
        chk_reg("rst_mask", ADDR_MASK, 32'h0);
        chk_reg("rst_pend", ADDR_PENDING, 32'h0);
        chk_reg("rst_id", ADDR_ID, 32'h0);
        chk_reg("rst_state", ADDR_STATE, 32'h0);

        // Single line 3: latency, accept, eret
        wr(ADDR_MASK, 32'hFFFF_FFFF);
        chk_reg("mask_rd", ADDR_MASK, 32'h0000_00FF);
        irq = 8'h08;
        step(2);
        chk_reg("l3_pend_early", ADDR_PENDING, 32'h0);
        step(1);
        chk_reg("l3_pend", ADDR_PENDING, 32'h08);
        chk("l3_ext_early", 32'(bus.o_external_interrupt), 32'h0);
        step(1);
        chk_req("l3_req", 1'b1, 4'd3);
        chk_reg("l3_idreg", ADDR_ID, 32'h8000_0003);
        chk_reg("l3_state_req", ADDR_STATE, 32'h1);
        irq = '0;
        pulse_exc();
        chk("l3_ext_acc", 32'(bus.o_external_interrupt), 32'h0);
        chk_reg("l3_pend_acc", ADDR_PENDING, 32'h0);
        chk_reg("l3_state_svc", ADDR_STATE, 32'h2);
        chk_reg("l3_idreg_svc", ADDR_ID, 32'h8000_0003);
        pulse_eret();
        chk_reg("l3_state_idle", ADDR_STATE, 32'h0);
        chk_reg("l3_idreg_idle", ADDR_ID, 32'h0000_0003);

        // Lines 5 and 2 together: priority and gap
        irq = 8'h24;
        step(3);
        chk_reg("pri_pend", ADDR_PENDING, 32'h24);
        step(1);
        chk_req("pri_first", 1'b1, 4'd2);
        irq = '0;
        pulse_exc();
        chk_reg("pri_pend_left", ADDR_PENDING, 32'h20);
        pulse_eret();
        chk("pri_gap", 32'(bus.o_external_interrupt), 32'h0);
        step(1);
        chk_req("pri_second", 1'b1, 4'd5);
        pulse_exc();
        pulse_eret();

        // Withdraw on mask, re-request on unmask
        irq = 8'h10;
        step(4);
        chk_req("wd_req", 1'b1, 4'd4);
        irq = '0;
        wr(ADDR_MASK, 32'h0000_00EF);
        step(1);
        chk("wd_ext", 32'(bus.o_external_interrupt), 32'h0);
        chk_reg("wd_state", ADDR_STATE, 32'h0);
        chk_reg("wd_pend", ADDR_PENDING, 32'h10);
        wr(ADDR_MASK, 32'h0000_00FF);
        step(1);
        chk_req("wd_rereq", 1'b1, 4'd4);
        pulse_exc();
        pulse_eret();

        // Re-pend of the in-service line
        irq = 8'h02;
        step(4);
        chk_req("rp_req", 1'b1, 4'd1);
        irq = '0;
        pulse_exc();
        step(2);
        irq = 8'h02;
        step(3);
        chk_reg("rp_pend", ADDR_PENDING, 32'h02);
        step(2);
        chk("rp_no_req", 32'(bus.o_external_interrupt), 32'h0);
        chk_reg("rp_state", ADDR_STATE, 32'h2);
        pulse_eret();
        chk("rp_gap", 32'(bus.o_external_interrupt), 32'h0);
        step(1);
        chk_req("rp_again", 1'b1, 4'd1);
        irq = '0;
        pulse_exc();
        pulse_eret();

        // Edge vs W1C race on line 6 with it masked
        wr(ADDR_MASK, 32'h0);
        irq = 8'h40;
        step(2);
        wr(ADDR_PENDING, 32'h40);
        chk_reg("race_set_wins", ADDR_PENDING, 32'h40);
        irq = '0;
        wr(ADDR_PENDING, 32'h40);
        chk_reg("w1c_clear", ADDR_PENDING, 32'h0);
        wr(ADDR_ID, 32'hFFFF_FFFF);
        chk_reg("id_ro", ADDR_ID, 32'h0000_0001);

        // Asynchronous reset during REQUEST, then stray eret
        wr(ADDR_MASK, 32'h0000_00FF);
        irq = 8'h01;
        step(4);
        chk_req("ar_req", 1'b1, 4'd0);
        irq = '0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_ext", 32'(bus.o_external_interrupt), 32'h0);
        chk_reg("ar_mask", ADDR_MASK, 32'h0);
        chk_reg("ar_pend", ADDR_PENDING, 32'h0);
        chk_reg("ar_state", ADDR_STATE, 32'h0);
        step(1);
        rst_n = 1'b1;
        step(1);
        pulse_eret();
        chk_reg("eret_idle_state", ADDR_STATE, 32'h0);
        chk("eret_idle_ext", 32'(bus.o_external_interrupt), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
